// File: rtl/note_sequencer.sv
// Programmable melody source: a writable note RAM stepped on fs ticks, driving the PWM tone stage.
// Optional feature macro NOTE_SEQ_REST_EN: stored pitch 0 becomes a muted rest.
module note_sequencer #(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int DEPTH_LOG2     = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fs_tick,
    input  logic                      wr_en,
    input  logic [DEPTH_LOG2-1:0]     wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    input  logic [DEPTH_LOG2:0]       len,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      stop,
    output logic [PITCH_BITWIDTH-1:0] pitch_o,
    output logic                      note_start,
    output logic                      playing,
    output logic                      done,
    output logic                      mute_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    localparam logic [DEPTH_LOG2:0]       LEN_MAX  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]       LEN_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0]     IDX_ONE  = DEPTH_LOG2'(1);
    localparam logic [DUR_BITWIDTH-1:0]   DUR_ONE  = DUR_BITWIDTH'(1);
    localparam logic [PITCH_BITWIDTH-1:0] PITCH_IDLE = '1;

    logic [PITCH_BITWIDTH-1:0] mem_pitch [DEPTH];
    logic [DUR_BITWIDTH-1:0]   mem_dur   [DEPTH];

    logic [1:0]                state_q, state_d;
    logic [DEPTH_LOG2-1:0]     idx_q, idx_d;
    logic [DEPTH_LOG2:0]       len_q, len_d;
    logic [DUR_BITWIDTH-1:0]   ctr_q, ctr_d;
    logic [DUR_BITWIDTH-1:0]   dur_q, dur_d;
    logic [PITCH_BITWIDTH-1:0] pitch_q, pitch_d;
    logic                      note_start_q, note_start_d;
    logic                      done_q, done_d;
    logic                      mute_q, mute_d;

    logic [PITCH_BITWIDTH-1:0] rd_pitch;
    logic [DUR_BITWIDTH-1:0]   rd_dur;
    logic                      last_note;

    // RAM contents survive reset; the read is captured at the LOAD->PLAY edge, so a
    // write landing on that same edge is not yet visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pitch[wr_addr] <= wr_pitch;
            mem_dur[wr_addr]   <= wr_dur;
        end
    end

    assign rd_pitch  = mem_pitch[idx_q];
    assign rd_dur    = mem_dur[idx_q];
    assign last_note = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        ctr_d        = ctr_q;
        dur_d        = dur_q;
        pitch_d      = pitch_q;
        mute_d       = mute_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            pitch_d = PITCH_IDLE;
            mute_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    end
                end
                ST_LOAD: begin
                    state_d      = ST_PLAY;
                    note_start_d = 1'b1;
                    ctr_d        = '0;
                    dur_d        = (rd_dur == '0) ? DUR_ONE : rd_dur;
`ifdef NOTE_SEQ_REST_EN
                    if (rd_pitch == '0) begin
                        pitch_d = PITCH_IDLE;
                        mute_d  = 1'b1;
                    end else begin
                        pitch_d = rd_pitch;
                        mute_d  = 1'b0;
                    end
`else
                    pitch_d = rd_pitch;
`endif
                end
                ST_PLAY: begin
                    // Ticks are counted only in PLAY, so the count restarts cleanly per note.
                    if (fs_tick) begin
                        if (ctr_q == (dur_q - DUR_ONE)) begin
                            if (!last_note) begin
                                idx_d   = idx_q + IDX_ONE;
                                state_d = ST_LOAD;
                            end else if (loop_en) begin
                                idx_d   = '0;
                                state_d = ST_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                                pitch_d = PITCH_IDLE;
                                mute_d  = 1'b0;
                            end
                        end else begin
                            ctr_d = ctr_q + DUR_ONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            ctr_q        <= '0;
            dur_q        <= '0;
            pitch_q      <= PITCH_IDLE;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
            mute_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            ctr_q        <= ctr_d;
            dur_q        <= dur_d;
            pitch_q      <= pitch_d;
            note_start_q <= note_start_d;
            done_q       <= done_d;
            mute_q       <= mute_d;
        end
    end

    assign pitch_o    = pitch_q;
    assign note_start = note_start_q;
    assign done       = done_q;
    assign mute_o     = mute_q;
    assign playing    = (state_q == ST_LOAD) || (state_q == ST_PLAY);

endmodule
